cache_control: RTL

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/lc3b_types.sv | 17 +
 rtl/cache_control.sv | 119 +++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b two-way set-associative cache controller.
package lc3b_types;

  localparam int unsigned NUM_WAYS = 2;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  // One-hot per-way enable for the selected way.
  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
    way_onehot = {way, ~way};
  endfunction

endpackage

// File: rtl/cache_control.sv
// Two-way cache controller: hit service in CHECK, dirty-victim WRITEBACK,
// line fill in ALLOCATE. Outputs decode combinationally from state and inputs.
module cache_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic       hit0,
  input  logic       hit1,
  input  logic       lru,
  input  logic       dirty_victim,
  input  logic       pmem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       way_select,
  output logic [1:0] load_way,
  output logic [1:0] set_dirty,
  output logic [1:0] clr_dirty,
  output logic       load_lru,
  output logic       lru_in,
  output logic       pmem_addr_sel,
  output logic       data_in_sel
);

  cache_state_t state_r;
  cache_state_t next_state_s;
  logic         request_s;
  logic         any_hit_s;
  logic         hit_way_s;

  // State register; reset abandons any line transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CHECK;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; outputs are forced quiet while in reset.
  always_comb begin
    next_state_s  = state_r;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_select    = 1'b0;
    load_way      = 2'b00;
    set_dirty     = 2'b00;
    clr_dirty     = 2'b00;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    request_s     = mem_read | mem_write;
    any_hit_s     = hit0 | hit1;
    hit_way_s     = ~hit0;

    if (!rst_n) begin
      next_state_s = CHECK;
    end else begin
      case (state_r)
        CHECK: begin
          if (request_s && any_hit_s) begin
            mem_resp   = 1'b1;
            way_select = hit_way_s;
            load_lru   = 1'b1;
            lru_in     = ~hit_way_s;
            // A simultaneous read and write is served as a write.
            if (mem_write) begin
              load_way    = way_onehot(hit_way_s);
              set_dirty   = way_onehot(hit_way_s);
              data_in_sel = 1'b1;
            end else begin
              data_in_sel = 1'b0;
            end
            next_state_s = CHECK;
          end else if (request_s) begin
            if (dirty_victim) begin
              next_state_s = WRITEBACK;
            end else begin
              next_state_s = ALLOCATE;
            end
          end else begin
            next_state_s = CHECK;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_select    = lru;
          if (pmem_resp) begin
            next_state_s = ALLOCATE;
          end else begin
            next_state_s = WRITEBACK;
          end
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = 1'b0;
          data_in_sel   = 1'b0;
          if (pmem_resp) begin
            load_way     = way_onehot(lru);
            clr_dirty    = way_onehot(lru);
            next_state_s = CHECK;
          end else begin
            next_state_s = ALLOCATE;
          end
        end
        default: begin
          next_state_s = CHECK;
        end
      endcase
    end
  end

endmodule
